n64_console_host: RTL and testbench
===================================

N64_CONSOLE_HOST -- requirements
Module: n64_console_host

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 2, giving sample_clk cycles per microsecond (2 MHz sample_clk).
REQ-002 SHALL have parameter TIMEOUT_US, default 100, giving the maximum line-idle gap in microseconds while awaiting response edges.
REQ-003 SHALL have port sample_clk, input, width 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, width 1: reset is synchronous and active-high.
REQ-005 SHALL have port poll_req, input, width 1: a 1-cycle pulse that starts one poll transaction.
REQ-006 SHALL have port data_rx, input, width 1: raw, asynchronous open-drain data line level.
REQ-007 SHALL have port data_tx, output, width 1: 1 pulls the line low; 0 releases it.
REQ-008 SHALL have port busy, output, width 1: high from poll acceptance until the DONE or ERROR state is left.
REQ-009 SHALL have port button_state, output, width 16: response bits 31..16, first received bit at MSB.
REQ-010 SHALL have port joy_x, output, width 8: response bits 15..8.
REQ-011 SHALL have port joy_y, output, width 8: response bits 7..0.
REQ-012 SHALL have port valid, output, width 1: a 1-cycle pulse when the outputs update.
REQ-013 SHALL have port timeout_err, output, width 1: a 1-cycle pulse when a transaction aborts.

Function
REQ-014 SHALL pass data_rx through a 2-flop synchronizer; all decoding SHALL use the synchronized value (2-cycle latency).
REQ-015 SHALL implement these FSM states: IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_STOP, DONE, ERROR.
REQ-016 IDLE: when poll_req=1, SHALL latch command 8'h01, assert busy, and go to TX_BIT on the next cycle; poll_req is ignored in every other state.
REQ-017 TX_BIT: SHALL send 8 bits, MSB first, each lasting 4*CLK_PER_US cycles.
- '0' bit: 3 us low, then 1 us released.
- '1' bit: 1 us low, then 3 us released.
REQ-018 TX_STOP: SHALL drive 1 us low, then release for 2 us, then go to RX_WAIT.
- At defaults, data_tx activity totals exactly 70 cycles.
REQ-019 RX_WAIT and RX_BIT: on each synchronized falling edge, SHALL sample the line 2*CLK_PER_US cycles later.
- Low sample = 0, high sample = 1.
- Shift the sample into a 32-bit register, MSB first.
REQ-020 After 32 bits, SHALL go to RX_STOP and require one further falling edge (the responder stop bit); its sampled value is don't-care.
REQ-021 SHALL run an idle counter in RX_WAIT, RX_BIT and RX_STOP that resets on every falling edge.
- On reaching TIMEOUT_US*CLK_PER_US cycles: go to ERROR.
REQ-022 DONE: SHALL load button_state, joy_x and joy_y from the shift register and pulse valid for 1 cycle, then go to IDLE.
REQ-023 ERROR: SHALL pulse timeout_err for 1 cycle, leave button_state, joy_x and joy_y unchanged, then go to IDLE.
REQ-024 data_tx SHALL be 0 in every state except IDLE-to-TX_STOP drive-low phases; it is never asserted while receiving.
REQ-025 A falling edge during TX states (line echo) SHALL be ignored.

Reset
REQ-026 On reset=1, SHALL on the next edge set state IDLE, data_tx=0, busy=0, valid=0, timeout_err=0, button_state=16'h0000, joy_x=8'h00, joy_y=8'h00, and clear all counters and the synchronizer.
REQ-027 Reset asserted mid-transaction SHALL abort it with no valid or timeout_err pulse; the line is released within 1 cycle.

Structure
REQ-028 Package n64_pkg SHALL hold the command constants (CMD_POLL=8'h01, CMD_INFO=8'h00), RESP_BITS=32, bit-timing constants in microseconds, and the FSM state enum.
REQ-029 Sub-module n64_rx_sync SHALL contain the 2-flop synchronizer and a falling-edge detect pulse output.

Verification
REQ-030 Poll with a controller model replying 32'h8000_7F81 plus stop -> button_state=16'h8000, joy_x=8'h7F, joy_y=8'h81, valid pulses once, busy low after.
REQ-031 Capture data_tx after poll_req -> seven (6 low, 2 high) cycle bits, then (2 low, 6 high), then stop (2 low, 4 high): 70 cycles total.
REQ-032 No controller response -> timeout_err pulses exactly 200 cycles after TX_STOP ends; outputs keep prior values; valid stays 0.
REQ-033 Responder sends 16 bits then goes silent -> timeout_err pulses; button_state is unchanged from the previous good poll.
REQ-034 reset asserted at response bit 10 -> all outputs return to reset values next cycle; a new poll then completes normally.
REQ-035 Second poll_req pulse during RX_BIT -> ignored; exactly one valid pulse results.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared constants and state encoding for the N64 console-side poll host.
package n64_pkg;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam int         RESP_BITS = 32;

  // Line timing in microseconds.
  localparam int T_BIT_US       = 4;
  localparam int T_SHORT_US     = 1;
  localparam int T_LONG_US      = 3;
  localparam int T_STOP_LOW_US  = 1;
  localparam int T_STOP_HIGH_US = 2;
  localparam int T_SAMPLE_US    = 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TX_BIT, ST_TX_STOP, ST_RX_WAIT,
    ST_RX_BIT, ST_RX_STOP, ST_DONE, ST_ERROR
  } state_e;
endpackage

// File: rtl/n64_rx_sync.sv
// Two-flop synchronizer for the open-drain data line plus falling-edge pulse.
module n64_rx_sync (
  input  logic sample_clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign fall_o = s3_q & ~s2_q;
endmodule

// File: rtl/n64_console_host.sv
// Console-side host: sends the poll command, then decodes the 32-bit controller reply.
module n64_console_host
  import n64_pkg::*;
#(
  parameter int CLK_PER_US = 2,
  parameter int TIMEOUT_US = 100
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        data_rx,
  output logic        data_tx,
  output logic        busy,
  output logic [15:0] button_state,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y,
  output logic        valid,
  output logic        timeout_err
);
  localparam logic [31:0] BIT_CYC     = 32'(T_BIT_US * CLK_PER_US);
  localparam logic [31:0] SHORT_CYC   = 32'(T_SHORT_US * CLK_PER_US);
  localparam logic [31:0] LONG_CYC    = 32'(T_LONG_US * CLK_PER_US);
  localparam logic [31:0] STOP_LO_CYC = 32'(T_STOP_LOW_US * CLK_PER_US);
  localparam logic [31:0] STOP_CYC    = 32'((T_STOP_LOW_US + T_STOP_HIGH_US) * CLK_PER_US);
  localparam logic [31:0] SAMP_CYC    = 32'(T_SAMPLE_US * CLK_PER_US);
  localparam logic [31:0] TMO_CYC     = 32'(TIMEOUT_US * CLK_PER_US);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, idle_q, idle_d, samp_q, samp_d, shift_q, shift_d;
  logic [7:0]  cmd_q, cmd_d, jx_q, jx_d, jy_q, jy_d;
  logic [15:0] btn_q, btn_d;
  logic [5:0]  bit_q, bit_d;
  logic        pend_q, pend_d;
  logic        rx_s, rx_fall;

  n64_rx_sync u_sync (
    .sample_clk (sample_clk),
    .reset      (reset),
    .d_i        (data_rx),
    .q_o        (rx_s),
    .fall_o     (rx_fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    cmd_d   = cmd_q;
    bit_d   = bit_q;
    pend_d  = pend_q;
    btn_d   = btn_q;
    jx_d    = jx_q;
    jy_d    = jy_q;
    case (state_q)
      ST_IDLE: if (poll_req) begin
        cmd_d   = CMD_POLL;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = ST_TX_BIT;
      end
      ST_TX_BIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == BIT_CYC - 32'd1) begin
          cnt_d = '0;
          cmd_d = {cmd_q[6:0], 1'b0};
          bit_d = bit_q + 6'd1;
          if (bit_q == 6'd7) begin
            bit_d   = '0;
            state_d = ST_TX_STOP;
          end
        end
      end
      ST_TX_STOP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == STOP_CYC - 32'd1) begin
          idle_d  = '0;
          pend_d  = 1'b0;
          bit_d   = '0;
          shift_d = '0;
          state_d = ST_RX_WAIT;
        end
      end
      ST_RX_WAIT, ST_RX_BIT, ST_RX_STOP: begin
        idle_d = idle_q + 32'd1;
        if (pend_q) begin
          samp_d = samp_q + 32'd1;
          if (samp_q == SAMP_CYC - 32'd1) begin
            shift_d = {shift_q[30:0], rx_s};
            pend_d  = 1'b0;
            bit_d   = bit_q + 6'd1;
            if (bit_q == 6'(RESP_BITS - 1)) state_d = ST_RX_STOP;
          end
        end
        if (rx_fall) begin
          idle_d = '0;
          if (state_q == ST_RX_STOP) begin
            btn_d   = shift_q[31:16];
            jx_d    = shift_q[15:8];
            jy_d    = shift_q[7:0];
            state_d = ST_DONE;
          end else begin
            pend_d  = 1'b1;
            samp_d  = '0;
            state_d = ST_RX_BIT;
          end
        end else if (idle_q == TMO_CYC - 32'd1) begin
          state_d = ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;  // DONE / ERROR last exactly one cycle
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      cmd_q   <= '0;
      bit_q   <= '0;
      pend_q  <= 1'b0;
      btn_q   <= '0;
      jx_q    <= '0;
      jy_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      cmd_q   <= cmd_d;
      bit_q   <= bit_d;
      pend_q  <= pend_d;
      btn_q   <= btn_d;
      jx_q    <= jx_d;
      jy_q    <= jy_d;
    end
  end

  // Line is only ever pulled low during the command and its stop bit.
  assign data_tx = ((state_q == ST_TX_BIT)  && (cnt_q < (cmd_q[7] ? SHORT_CYC : LONG_CYC))) ||
                   ((state_q == ST_TX_STOP) && (cnt_q < STOP_LO_CYC));
  assign busy         = (state_q != ST_IDLE);
  assign valid        = (state_q == ST_DONE);
  assign timeout_err  = (state_q == ST_ERROR);
  assign button_state = btn_q;
  assign joy_x        = jx_q;
  assign joy_y        = jy_q;
endmodule

// File: tb/tb_n64_console_host.sv
// Directed bench: drives a controller model on the open-drain line and checks decode results.
module tb_n64_console_host;
  logic        sample_clk = 1'b0;
  logic        reset = 1'b1;
  logic        poll_req = 1'b0;
  logic        ctl_low = 1'b0;
  logic        data_rx, data_tx, busy, valid, timeout_err;
  logic [15:0] button_state;
  logic [7:0]  joy_x, joy_y;
  int          nchk = 0;
  int          nfail = 0;
  int          valid_cnt = 0;
  int          tmo_cnt = 0;

  always #5 sample_clk = ~sample_clk;

  assign data_rx = ~(data_tx | ctl_low);

  n64_console_host dut (
    .sample_clk   (sample_clk),
    .reset        (reset),
    .poll_req     (poll_req),
    .data_rx      (data_rx),
    .data_tx      (data_tx),
    .busy         (busy),
    .button_state (button_state),
    .joy_x        (joy_x),
    .joy_y        (joy_y),
    .valid        (valid),
    .timeout_err  (timeout_err)
  );

  always @(posedge sample_clk) begin
    if (valid)       valid_cnt <= valid_cnt + 1;
    if (timeout_err) tmo_cnt   <= tmo_cnt + 1;
  end

  // Controller reply: 4 us per bit, '0' = 3 us low, '1' = 1 us low; optional stop bit.
  task automatic send_reply(input logic [31:0] d, input int nbits, input bit stop, input int poll_at);
    int lo;
    for (int i = 0; i < nbits; i++) begin
      lo = d[31-i] ? 2 : 6;
      ctl_low  = 1'b1;
      poll_req = (i == poll_at);
      @(negedge sample_clk);
      poll_req = 1'b0;
      repeat (lo - 1) @(negedge sample_clk);
      ctl_low = 1'b0;
      repeat (8 - lo) @(negedge sample_clk);
    end
    if (stop) begin
      ctl_low = 1'b1;
      repeat (2) @(negedge sample_clk);
      ctl_low = 1'b0;
      repeat (10) @(negedge sample_clk);
    end
  endtask

  task automatic do_poll();
    @(negedge sample_clk);
    poll_req = 1'b1;
    @(negedge sample_clk);
    poll_req = 1'b0;
    repeat (80) @(negedge sample_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sample_clk);
    nchk++; if (data_tx !== 1'b0)      begin nfail++; $display("FAIL rst_data_tx got %b exp 0", data_tx); end
    nchk++; if (busy !== 1'b0)         begin nfail++; $display("FAIL rst_busy got %b exp 0", busy); end
    nchk++; if (valid !== 1'b0)        begin nfail++; $display("FAIL rst_valid got %b exp 0", valid); end
    nchk++; if (timeout_err !== 1'b0)  begin nfail++; $display("FAIL rst_timeout got %b exp 0", timeout_err); end
    nchk++; if ({button_state, joy_x, joy_y} !== 32'h0)
      begin nfail++; $display("FAIL rst_outputs got %h exp 00000000", {button_state, joy_x, joy_y}); end
    reset = 1'b0;
    repeat (2) @(negedge sample_clk);
  endtask

  task automatic test_poll();
    int vb, errs;
    logic exp_tx;
    vb = valid_cnt;
    errs = 0;
    @(negedge sample_clk);
    poll_req = 1'b1;
    @(negedge sample_clk);
    poll_req = 1'b0;
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL poll_busy got %b exp 1", busy); end
    for (int k = 0; k < 71; k++) begin
      if (k < 64) exp_tx = ((k % 8) < ((k / 8 == 7) ? 2 : 6));
      else        exp_tx = ((k - 64) < 2);
      if (k == 70) exp_tx = 1'b0;
      if (data_tx !== exp_tx) errs++;
      @(negedge sample_clk);
    end
    nchk++; if (errs != 0) begin nfail++; $display("FAIL tx_waveform got %0d bad cycles exp 0", errs); end
    repeat (9) @(negedge sample_clk);
    send_reply(32'h8000_7F81, 32, 1'b1, -1);
    nchk++; if (button_state !== 16'h8000) begin nfail++; $display("FAIL poll_buttons got %h exp 8000", button_state); end
    nchk++; if (joy_x !== 8'h7F) begin nfail++; $display("FAIL poll_joy_x got %h exp 7f", joy_x); end
    nchk++; if (joy_y !== 8'h81) begin nfail++; $display("FAIL poll_joy_y got %h exp 81", joy_y); end
    nchk++; if (valid_cnt - vb != 1) begin nfail++; $display("FAIL poll_valid_count got %0d exp 1", valid_cnt - vb); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL poll_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_no_response();
    int vb, tb, k;
    vb = valid_cnt;
    tb = tmo_cnt;
    @(negedge sample_clk);
    poll_req = 1'b1;
    @(negedge sample_clk);
    poll_req = 1'b0;
    k = 0;
    while (timeout_err !== 1'b1 && k < 600) begin
      @(negedge sample_clk);
      k++;
    end
    // 70 cycles of command + 200 idle cycles
    nchk++; if (k != 270) begin nfail++; $display("FAIL timeout_latency got %0d exp 270", k); end
    repeat (3) @(negedge sample_clk);
    nchk++; if (tmo_cnt - tb != 1) begin nfail++; $display("FAIL timeout_count got %0d exp 1", tmo_cnt - tb); end
    nchk++; if (valid_cnt != vb) begin nfail++; $display("FAIL timeout_valid got %0d exp 0", valid_cnt - vb); end
    nchk++; if ({button_state, joy_x, joy_y} !== 32'h8000_7F81)
      begin nfail++; $display("FAIL timeout_hold got %h exp 80007f81", {button_state, joy_x, joy_y}); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL timeout_busy got %b exp 0", busy); end
  endtask

  task automatic test_partial();
    int tb, k;
    tb = tmo_cnt;
    do_poll();
    send_reply(32'h1111_2222, 16, 1'b0, -1);
    k = 0;
    while (tmo_cnt == tb && k < 400) begin
      @(negedge sample_clk);
      k++;
    end
    nchk++; if (tmo_cnt - tb != 1) begin nfail++; $display("FAIL partial_timeout got %0d exp 1", tmo_cnt - tb); end
    nchk++; if (button_state !== 16'h8000) begin nfail++; $display("FAIL partial_hold got %h exp 8000", button_state); end
  endtask

  task automatic test_reset_mid();
    int vb, tb;
    vb = valid_cnt;
    tb = tmo_cnt;
    do_poll();
    send_reply(32'hFFFF_FFFF, 10, 1'b0, -1);
    ctl_low = 1'b1;
    repeat (2) @(negedge sample_clk);
    reset = 1'b1;
    @(negedge sample_clk);
    ctl_low = 1'b0;
    nchk++; if ({data_tx, busy, valid, timeout_err} !== 4'b0000)
      begin nfail++; $display("FAIL midrst_ctrl got %b exp 0000", {data_tx, busy, valid, timeout_err}); end
    nchk++; if ({button_state, joy_x, joy_y} !== 32'h0)
      begin nfail++; $display("FAIL midrst_outputs got %h exp 00000000", {button_state, joy_x, joy_y}); end
    reset = 1'b0;
    repeat (5) @(negedge sample_clk);
    nchk++; if (valid_cnt != vb || tmo_cnt != tb)
      begin nfail++; $display("FAIL midrst_pulses got v%0d t%0d exp 0", valid_cnt - vb, tmo_cnt - tb); end
    do_poll();
    send_reply(32'h1234_5678, 32, 1'b1, -1);
    nchk++; if ({button_state, joy_x, joy_y} !== 32'h1234_5678)
      begin nfail++; $display("FAIL midrst_repoll got %h exp 12345678", {button_state, joy_x, joy_y}); end
    nchk++; if (valid_cnt - vb != 1) begin nfail++; $display("FAIL midrst_valid got %0d exp 1", valid_cnt - vb); end
  endtask

  task automatic test_double_poll();
    int vb;
    vb = valid_cnt;
    do_poll();
    send_reply(32'hA5A5_0F0F, 32, 1'b1, 5);
    repeat (100) @(negedge sample_clk);
    nchk++; if ({button_state, joy_x, joy_y} !== 32'hA5A5_0F0F)
      begin nfail++; $display("FAIL dbl_outputs got %h exp a5a50f0f", {button_state, joy_x, joy_y}); end
    nchk++; if (valid_cnt - vb != 1) begin nfail++; $display("FAIL dbl_valid got %0d exp 1", valid_cnt - vb); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL dbl_busy got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_poll();
    test_no_response();
    test_partial();
    test_reset_mid();
    test_double_poll();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
